// File: rtl/riscv_pkg.sv
// Shared pipeline constants for the five-stage RISC-V core.
package riscv_pkg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Clears the two low address bits; RV32I without C fetches whole words only.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (hazard unit, EX, imem, decode).
// Control inputs are level signals sampled on the rising clock edge; there is no
// valid/ready handshake: id_valid only qualifies the IF/ID contents for decode.
interface if_stage_if;
  import riscv_pkg::*;

  logic                 stall;
  logic                 debug;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_target;
  logic [XLEN-1:0]      imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      id_pc;
  logic [INSTR_W-1:0]   id_instr;
  logic                 id_valid;
  logic [CNT_W-1:0]     fetch_count;

  // Fetch stage side.
  modport master (
    input  stall, debug, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, pc, id_pc, id_instr, id_valid, fetch_count
  );

  // Environment side: hazard unit, EX, instruction memory and decode.
  modport slave (
    output stall, debug, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, pc, id_pc, id_instr, id_valid, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register with load / hold / flush-to-NOP and a valid bit.
// Priority: rst > flush > load > hold.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                load,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic [XLEN-1:0]     out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_valid
);

  // Register the entry; reset and flush both leave a NOP bubble behind.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
      out_valid <= 1'b0;
    end else if (load) begin
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch counter and IF/ID register.
module if_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] count_q;
  logic             hold;
  logic             advance;

  // Redirect beats a hold, so only a non-redirecting, non-held edge fetches.
  assign hold    = bus.stall | bus.debug;
  assign advance = ~bus.redirect_valid & ~hold;

  // imem is combinational, so the address is simply the current PC.
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_count = count_q;

  // PC register: reset, redirect (word aligned), hold, or sequential +4 (wraps).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_q <= word_align(bus.redirect_target);
    end else if (!hold) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  // Count every instruction accepted into IF/ID; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (advance) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .load      (advance),
    .in_pc     (pc_q),
    .in_instr  (bus.imem_rdata),
    .out_pc    (bus.id_pc),
    .out_instr (bus.id_instr),
    .out_valid (bus.id_valid)
  );

endmodule
